// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential signed 14-bit binary to 4-digit BCD converter.
// A start strobe in IDLE latches the operand. The block then runs one
// shift-add-3 (double-dabble) iteration per clock for 14 clocks and loads
// four BCD digits, a sign flag and a leading-zero blank mask.
//
// Ports:
//   i_cclk              system clock, rising edge
//   i_rst_n             asynchronous active-low reset
//   i_start             conversion request, only looked at in IDLE
//   i_value[13:0]       two's-complement operand, sampled on the accepting edge
//   o_busy              high while a conversion is running
//   o_done              one-cycle pulse when new results are loaded
//   o_dig0..o_dig3      BCD units / tens / hundreds / thousands
//   o_sign              operand was negative
//   o_blank[3:0]        bit i set: o_digi is a suppressed leading zero
// Parameter LZB: leading-zero blanking enable (0 keeps o_blank at 0).
module bin2bcd_seq #(
    parameter bit LZB = 1'b1
) (
    input  logic        i_cclk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [13:0] i_value,
    output logic        o_busy,
    output logic        o_done,
    output logic [3:0]  o_dig0,
    output logic [3:0]  o_dig1,
    output logic [3:0]  o_dig2,
    output logic [3:0]  o_dig3,
    output logic        o_sign,
    output logic [3:0]  o_blank
);
    localparam int NDIG = 4;
    localparam int NBIN = 14;
    localparam int SRW  = NBIN + 4*NDIG;
    localparam logic [3:0] BLANK_RST = LZB ? 4'b1110 : 4'b0000;

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [SRW-1:0]        r_sr;
    logic                  r_sign_next;
    logic                  r_busy;
    logic                  r_done;
    logic [NDIG-1:0][3:0]  r_dig;
    logic                  r_sign;
    logic [3:0]            r_blank;

    logic [NDIG-1:0][3:0]  w_bcd_adj;
    logic [SRW-1:0]        w_adj;
    logic [SRW-1:0]        w_shift;
    logic [NDIG-1:0][3:0]  w_res;
    logic [13:0]           w_mag;
    logic [3:0]            w_blank;

    // Add-3 correction on every BCD nibble before the shift.
    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        assign w_bcd_adj[g] = (r_sr[NBIN+4*g +: 4] >= 4'd5) ?
                              r_sr[NBIN+4*g +: 4] + 4'd3 :
                              r_sr[NBIN+4*g +: 4];
    end

    assign w_adj   = {w_bcd_adj, r_sr[NBIN-1:0]};
    assign w_shift = {w_adj[SRW-2:0], 1'b0};
    assign w_res   = w_shift[SRW-1:NBIN];

    // -8192 negates to 14'h2000, which read as unsigned is 8192.
    assign w_mag = i_value[13] ? (~i_value + 14'd1) : i_value;

    always_comb begin
        w_blank = 4'b0000;
        if (LZB) begin
            w_blank[3] = (w_res[3] == 4'd0);
            w_blank[2] = w_blank[3] & (w_res[2] == 4'd0);
            w_blank[1] = w_blank[2] & (w_res[1] == 4'd0);
        end
    end

    always_ff @(posedge i_cclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_sr        <= '0;
            r_sign_next <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dig       <= '0;
            r_sign      <= 1'b0;
            r_blank     <= BLANK_RST;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_sign_next <= i_value[13];
                        r_sr        <= {{(4*NDIG){1'b0}}, w_mag};
                        r_cnt       <= 4'd0;
                        r_busy      <= 1'b1;
                        r_state     <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_sr  <= w_shift;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd13) begin
                        r_dig   <= w_res;
                        r_sign  <= r_sign_next;
                        r_blank <= w_blank;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_dig0  = r_dig[0];
    assign o_dig1  = r_dig[1];
    assign o_dig2  = r_dig[2];
    assign o_dig3  = r_dig[3];
    assign o_sign  = r_sign;
    assign o_blank = r_blank;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: two instances (blanking on / off) share stimulus.
// A cycle-level behavioural model computes results with plain decimal
// arithmetic and is compared against both instances on every falling edge.
module tb_bin2bcd_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [13:0] value;

    logic        busy1, done1, sign1;
    logic [3:0]  d0a, d1a, d2a, d3a, blank1;
    logic        busy0, done0, sign0;
    logic [3:0]  d0b, d1b, d2b, d3b, blank0;

    int n_cmp = 0;
    int n_err = 0;
    bit en    = 1'b0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.LZB(1'b1)) dut (
        .i_cclk(clk), .i_rst_n(rst_n), .i_start(start), .i_value(value),
        .o_busy(busy1), .o_done(done1), .o_dig0(d0a), .o_dig1(d1a),
        .o_dig2(d2a), .o_dig3(d3a), .o_sign(sign1), .o_blank(blank1));

    bin2bcd_seq #(.LZB(1'b0)) dut_nolzb (
        .i_cclk(clk), .i_rst_n(rst_n), .i_start(start), .i_value(value),
        .o_busy(busy0), .o_done(done0), .o_dig0(d0b), .o_dig1(d1b),
        .o_dig2(d2b), .o_dig3(d3b), .o_sign(sign0), .o_blank(blank0));

    wire [15:0] dig1 = {d3a, d2a, d1a, d0a};
    wire [15:0] dig0 = {d3b, d2b, d1b, d0b};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal digits of |v| as four packed BCD nibbles.
    function automatic logic [15:0] ref_bcd(input logic [13:0] v);
        int mag;
        logic [3:0] th, hu, te, un;
        mag = v[13] ? 16384 - int'(v) : int'(v);
        th = 4'((mag / 1000) % 10);
        hu = 4'((mag / 100) % 10);
        te = 4'((mag / 10) % 10);
        un = 4'(mag % 10);
        return {th, hu, te, un};
    endfunction

    function automatic logic [3:0] ref_blank(input logic [15:0] d);
        logic b3, b2, b1;
        b3 = (d[15:12] == 4'd0);
        b2 = b3 && (d[11:8] == 4'd0);
        b1 = b2 && (d[7:4] == 4'd0);
        return {b3, b2, b1, 1'b0};
    endfunction

    // Behavioural model: an accepted request yields its result 14 edges later.
    logic        m_busy = 1'b0, m_done = 1'b0, m_sign = 1'b0;
    logic [15:0] m_dig = 16'h0;
    logic [3:0]  m_blank = 4'b1110;
    logic [15:0] p_dig;
    logic        p_sign;
    int          m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_busy = 0; m_done = 0;
            m_dig = 16'h0; m_sign = 0; m_blank = 4'b1110;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_dig = p_dig; m_sign = p_sign; m_blank = ref_blank(p_dig);
                    m_done = 1; m_busy = 0;
                end
            end else if (start) begin
                p_dig = ref_bcd(value); p_sign = value[13];
                m_left = 14; m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (en) begin
            chk("busy",         busy1,  m_busy);
            chk("done",         done1,  m_done);
            chk("digits",       dig1,   m_dig);
            chk("sign",         sign1,  m_sign);
            chk("blank",        blank1, m_blank);
            chk("nolzb_done",   done0,  m_done);
            chk("nolzb_digits", dig0,   m_dig);
            chk("nolzb_sign",   sign0,  m_sign);
            chk("nolzb_blank",  blank0, 4'b0000);
        end
    end

    // Called just after a falling edge; returns the edge count to DONE.
    task automatic run_conv(input logic [13:0] v, output int lat, output int bcnt);
        start = 1'b1; value = v; lat = 0; bcnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (busy1) bcnt++;
            if (done1) begin lat = k; break; end
        end
    endtask

    int lat, bcnt, ndone, first_d, last_d, prev_d;

    initial begin
        rst_n = 1'b0; start = 1'b0; value = 14'd0;

        // model pins
        chk("model_1234",  ref_bcd(14'd1234),  16'h1234);
        chk("model_m8192", ref_bcd(14'h2000),  16'h8192);
        chk("model_m1",    ref_bcd(14'h3FFF),  16'h0001);
        chk("model_blank42", ref_blank(16'h0042), 4'b1100);

        repeat (3) @(negedge clk);
        chk("rst_busy",  busy1,  1'b0);
        chk("rst_done",  done1,  1'b0);
        chk("rst_dig",   dig1,   16'h0);
        chk("rst_sign",  sign1,  1'b0);
        chk("rst_blank", blank1, 4'b1110);
        chk("rst_blank_nolzb", blank0, 4'b0000);
        rst_n = 1'b1; en = 1'b1;
        @(negedge clk);

        run_conv(14'd1234, lat, bcnt);
        chk("lat_1234",   lat,  15);
        chk("busy_cycles", bcnt, 14);
        chk("dig_1234",   dig1, 16'h1234);
        chk("sign_1234",  sign1, 1'b0);
        chk("blank_1234", blank1, 4'b0000);

        run_conv(14'h2000, lat, bcnt);
        chk("dig_m8192",  dig1, 16'h8192);
        chk("sign_m8192", sign1, 1'b1);

        run_conv(14'h3FFF, lat, bcnt);
        chk("dig_m1",   dig1, 16'h0001);
        chk("sign_m1",  sign1, 1'b1);
        chk("blank_m1", blank1, 4'b1110);

        run_conv(14'd0, lat, bcnt);
        chk("dig_0",   dig1, 16'h0000);
        chk("sign_0",  sign1, 1'b0);
        chk("blank_0", blank1, 4'b1110);

        run_conv(14'd8191, lat, bcnt);
        chk("dig_8191", dig1, 16'h8191);

        run_conv(14'd5, lat, bcnt);
        chk("dig_5",         dig1,   16'h0005);
        chk("blank_5_nolzb", blank0, 4'b0000);

        // START pulses mid-conversion are ignored
        start = 1'b1; value = 14'd42; ndone = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            start = (k == 3 || k == 10);
            if (done1) ndone++;
        end
        start = 1'b0;
        chk("ignore_start_dones", ndone, 1);
        chk("dig_42",   dig1,   16'h0042);
        chk("blank_42", blank1, 4'b1100);

        // START held high: one DONE every 15 cycles
        start = 1'b1; value = 14'd77; ndone = 0; first_d = 0; last_d = 0; prev_d = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (done1) begin
                if (ndone == 0) first_d = k;
                else chk("done_spacing", k - prev_d, 15);
                prev_d = k; last_d = k; ndone++;
            end
        end
        start = 1'b0;
        chk("held_done_count", ndone, 3);
        chk("held_first_done", first_d, 15);
        repeat (20) @(negedge clk);
        chk("dig_77", dig1, 16'h0077);

        // VALUE change after acceptance has no effect; outputs held
        start = 1'b1; value = 14'd999; lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin start = 1'b0; value = 14'd7; end
            if (k == 5) chk("held_during_conv", dig1, 16'h0077);
            if (done1) begin lat = k; break; end
        end
        chk("lat_999",   lat,    15);
        chk("dig_999",   dig1,   16'h0999);
        chk("blank_999", blank1, 4'b1000);

        // reset mid-conversion
        start = 1'b1; value = 14'd555;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",  busy1,  1'b0);
        chk("arst_dig",   dig1,   16'h0);
        chk("arst_sign",  sign1,  1'b0);
        chk("arst_blank", blank1, 4'b1110);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done1) ndone++;
        end
        chk("arst_no_done", ndone, 0);
        chk("arst_idle",    busy1, 1'b0);

        run_conv(14'd100, lat, bcnt);
        chk("lat_100", lat, 15);
        chk("dig_100", dig1, 16'h0100);

        repeat (2) @(negedge clk);
        en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential signed-binary to 4-digit BCD converter that feeds the four-digit seven-segment display stage. It accepts a 14-bit two's-complement value on a start strobe and runs a shift-add-3 (double-dabble) conversion at one bit per clock. It then presents four stable BCD digits, a sign flag and a leading-zero blank mask. These outputs drive the per-digit seven-segment decoders (digit A–D inputs, Sign input) directly.

## Interface
- LZB, default 1: leading-zero blanking enable; 0 forces BLANK to 4'b0000.
- CCLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  conversion request; sampled only in IDLE.
- VALUE  input  14  two's-complement operand (-8192..8191); sampled on the accepting edge only.
- BUSY  output  1  high while a conversion is in progress.
- DONE  output  1  one-cycle pulse when new results are loaded.
- DIG0  output  4  BCD units digit.
- DIG1  output  4  BCD tens digit.
- DIG2  output  4  BCD hundreds digit.
- DIG3  output  4  BCD thousands digit.
- SIGN  output  1  1 when the converted VALUE was negative.
- BLANK  output  4  per-digit blank mask; bit i set means DIGi is a suppressed leading zero.

## Operation
- Two states: IDLE and CONV.
- IDLE with START=1: accept the request.
  - Latch SIGN_next = VALUE[13].
  - Compute mag = |VALUE| as a 14-bit unsigned value; -8192 gives 8192, with no overflow.
  - Load the 30-bit shift register {bcd[15:0]=0, mag[13:0]}.
  - Clear the iteration counter (4 bits) and enter CONV.
- CONV, each cycle, one iteration:
  - Every BCD nibble ≥5 gets +3.
  - Then the whole register shifts left by 1.
  - The counter increments.
- On the 14th iteration (counter==13):
  - Load DIG3..DIG0 from the post-shift bcd field and load SIGN.
  - Compute BLANK and pulse DONE.
  - Return to IDLE.
- BLANK (LZB=1):
  - BLANK[3] = (DIG3==0).
  - BLANK[2] = BLANK[3] & (DIG2==0).
  - BLANK[1] = BLANK[2] & (DIG1==0).
  - BLANK[0] = 0 always, so the units digit is never blanked.
- Output holding: DIGx, SIGN and BLANK change only on the DONE edge and otherwise hold their last results, including throughout CONV.
- START while in CONV is ignored; there is no queueing.
- VALUE changes after acceptance have no effect on the conversion in progress.
- Results are always valid BCD (each digit 0–9); the maximum magnitude is 8192.

## Timing
- Reset (RST_N=0, asynchronous): IDLE, BUSY=0, DONE=0, DIG0..3=0, SIGN=0, BLANK=4'b1110 (4'b0000 if LZB=0), counter and shift register 0.
- Edge E0 samples START=1 in IDLE. BUSY is high from after E0 through E14 (14 cycles).
- E1..E14 perform the 14 iterations. Results load at E14, and DONE=1 for exactly the cycle after E14, with BUSY=0 in that cycle.
- Latency from the accepting edge to results visible is 14 cycles.
- Throughput is one conversion per 15 cycles: START held high re-accepts at E15, which is the DONE cycle's edge.
- Reset asserted mid-conversion:
  - The conversion is aborted and all outputs immediately take their reset values.
  - No DONE is produced.
  - After release the block sits in IDLE until START.

## Test plan
- Reset, then VALUE=1234 with START for 1 cycle -> DONE exactly 14 cycles after the accepting edge; DIG3..0=1,2,3,4; SIGN=0; BLANK=0000; BUSY high for 14 cycles.
- VALUE=14'h2000 (-8192) -> DIG3..0=8,1,9,2, SIGN=1. Then VALUE=14'h3FFF (-1) -> 0,0,0,1, SIGN=1, BLANK=1110.
- VALUE=0 -> all digits 0, SIGN=0, BLANK=1110. VALUE=8191 -> 8,1,9,1. VALUE=5 with LZB=0 -> BLANK=0000.
- START pulsed again at cycles 3 and 10 of a conversion of 42 -> ignored; a single DONE; DIG=0,0,4,2, BLANK=1100. START held high continuously -> DONE every 15 cycles.
- Change VALUE from 999 to 7 one cycle after acceptance -> result 0,9,9,9 with BLANK=1000; previous outputs are held unchanged until DONE.
- Assert RST_N=0 at cycle 7 of a conversion -> outputs go to reset values asynchronously with no DONE; after release, a START with 100 gives 0,1,0,0.
